// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the fixed-point square-root block.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_res_w(input int in_w, input int frac_w);
        return in_w / 2 + frac_w;
    endfunction

    function automatic int calc_niter(input int res_w, input int unroll);
        return (res_w + unroll - 1) / unroll;
    endfunction

endpackage

// File: rtl/sqrt_bound_check.sv
// Combinational self-check: confirms R^2 <= X < (R+1)^2 for a finished root.
module sqrt_bound_check #(
    parameter int RES_W = 24
) (
    input  logic [RES_W-1:0]   root_i,
    input  logic [2*RES_W-1:0] x_i,
    output logic               ok_o
);
    localparam int LW = 2 * RES_W;
    localparam int HW = 2 * RES_W + 2;

    logic [LW-1:0]  lo_sq;
    logic [RES_W:0] root_p1;
    logic [HW-1:0]  hi_sq;

    assign lo_sq   = LW'(root_i) * LW'(root_i);
    // One extra bit so an all-ones root does not wrap to zero.
    assign root_p1 = (RES_W+1)'(root_i) + (RES_W+1)'(1);
    assign hi_sq   = HW'(root_p1) * HW'(root_p1);
    assign ok_o    = (lo_sq <= x_i) && (HW'(x_i) < hi_sq);

endmodule

// File: rtl/sqrt_fixed_param.sv
// Iterative restoring square root of an unsigned radicand, UNROLL bits per clock,
// with a final bound self-check and optional single-bit fault injection.
module sqrt_fixed_param
    import sqrt_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 8,
    parameter int UNROLL = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  Start,
    input  logic [IN_W-1:0]                       InpNum,
    input  logic                                  InjFault,
    output logic [calc_res_w(IN_W, FRAC_W)-1:0]   Result,
    output logic                                  Busy,
    output logic                                  Done,
    output logic                                  Err
);
    localparam int RES_W = calc_res_w(IN_W, FRAC_W);
    localparam int NITER = calc_niter(RES_W, UNROLL);
    localparam int XW    = 2 * RES_W;
    localparam int CNT_W = $clog2(NITER + 1);
    localparam int IDX_W = $clog2(RES_W);

    if (IN_W < 4 || (IN_W % 2) != 0 || FRAC_W < 0 || (UNROLL != 1 && UNROLL != 2)) begin : g_param_check
        $error("sqrt_fixed_param: illegal parameter combination");
    end

    state_t             state_q;
    logic [XW-1:0]      x_q;
    logic [RES_W-1:0]   root_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fault_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [RES_W-1:0]   root_d;
    logic [RES_W-1:0]   cand;
    int                 bit_pos;
    logic               bound_ok;

    // Resolve up to UNROLL bits MSB-first; a negative position means the odd tail bit is already done.
    always_comb begin
        root_d  = root_q;
        cand    = '0;
        bit_pos = 0;
        for (int u = 0; u < UNROLL; u++) begin
            bit_pos = int'(idx_q) - u;
            if (bit_pos >= 0) begin
                cand = root_d | (RES_W'(1) << bit_pos);
                if (XW'(cand) * XW'(cand) <= x_q) begin
                    root_d = cand;
                end
            end
        end
    end

    sqrt_bound_check #(.RES_W(RES_W)) u_bound_check (
        .root_i (root_q),
        .x_i    (x_q),
        .ok_o   (bound_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            root_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        x_q     <= XW'(InpNum) << (2 * FRAC_W);
                        fault_q <= InjFault;
                        root_q  <= '0;
                        idx_q   <= IDX_W'(RES_W - 1);
                        cnt_q   <= CNT_W'(NITER);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    idx_q <= idx_q - IDX_W'(UNROLL);
                    if (cnt_q == CNT_W'(1)) begin
                        root_q  <= root_d ^ RES_W'(fault_q);
                        state_q <= CHECK;
                    end else begin
                        root_q  <= root_d;
                    end
                end
                CHECK: begin
                    err_q   <= ~bound_ok;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Result = root_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_sqrt_fixed_param.sv
// Bench for sqrt_fixed_param: four parameterisations checked against a real-valued sqrt model.
module tb_sqrt_fixed_param;

    logic        clk;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  fault;
    logic [31:0] inp [4];
    logic [3:0]  busy, done, err;
    logic [23:0] res_a, res_b;
    logic [8:0]  res_c;
    logic [7:0]  res_d;

    int vectors;
    int miscompares;

    // Instance k: A(32,8,1) B(32,8,2) C(16,1,2: odd RES_W) D(16,0,1)
    int NIT [4] = '{24, 12, 5, 8};
    int FR  [4] = '{8, 8, 1, 0};
    int INW [4] = '{32, 32, 16, 16};

    sqrt_fixed_param #(.IN_W(32), .FRAC_W(8), .UNROLL(1)) u_a (
        .clk(clk), .rst(rst), .Start(start[0]), .InpNum(inp[0]), .InjFault(fault[0]),
        .Result(res_a), .Busy(busy[0]), .Done(done[0]), .Err(err[0]));
    sqrt_fixed_param #(.IN_W(32), .FRAC_W(8), .UNROLL(2)) u_b (
        .clk(clk), .rst(rst), .Start(start[1]), .InpNum(inp[1]), .InjFault(fault[1]),
        .Result(res_b), .Busy(busy[1]), .Done(done[1]), .Err(err[1]));
    sqrt_fixed_param #(.IN_W(16), .FRAC_W(1), .UNROLL(2)) u_c (
        .clk(clk), .rst(rst), .Start(start[2]), .InpNum(inp[2][15:0]), .InjFault(fault[2]),
        .Result(res_c), .Busy(busy[2]), .Done(done[2]), .Err(err[2]));
    sqrt_fixed_param #(.IN_W(16), .FRAC_W(0), .UNROLL(1)) u_d (
        .clk(clk), .rst(rst), .Start(start[3]), .InpNum(inp[3][15:0]), .InjFault(fault[3]),
        .Result(res_d), .Busy(busy[3]), .Done(done[3]), .Err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] get_res(input int k);
        case (k)
            0:       return res_a;
            1:       return res_b;
            2:       return {15'b0, res_c};
            default: return {16'b0, res_d};
        endcase
    endfunction

    function automatic longint unsigned ref_sqrt(input int k, input longint unsigned v);
        longint unsigned x, r;
        x = v << (2 * FR[k]);
        r = longint'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation; optionally pulse Start (with other data) after edge `poke` while busy.
    task automatic op(input int k, input logic [31:0] v_in, input logic f, input int poke,
                      input string tag);
        int n;
        logic [31:0] v;
        longint unsigned exp_r;
        v = (INW[k] == 16) ? (v_in & 32'h0000_FFFF) : v_in;
        @(negedge clk);
        start[k] = 1'b1; inp[k] = v; fault[k] = f;
        @(posedge clk);
        #1 start[k] = 1'b0;
        chk({tag, "_busy"}, 64'(busy[k]), 64'd1);
        n = 0;
        while (!done[k] && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            start[k] = (n == poke);
            if (n == poke) inp[k] = ~v;
        end
        start[k] = 1'b0;
        exp_r = ref_sqrt(k, longint'(v));
        if (f) exp_r = exp_r ^ 1;
        chk({tag, "_lat"}, 64'(n), 64'(NIT[k] + 1));
        chk({tag, "_res"}, 64'(get_res(k)), 64'(exp_r));
        chk({tag, "_err"}, 64'(err[k]), 64'(f));
        chk({tag, "_nbusy"}, 64'(busy[k]), 64'd0);
    endtask

    initial begin
        int n, n2;
        logic seen_done;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = '0;
        fault = '0;
        for (int k = 0; k < 4; k++) inp[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_res%0d", k), 64'(get_res(k)), 64'd0);
            chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
            chk($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
            chk($sformatf("rst_err%0d", k), 64'(err[k]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed values with fixed expectations
        op(0, 32'd16, 1'b0, 0, "a16");
        chk("a16_const", 64'(res_a), 64'h400);
        op(0, 32'd2, 1'b0, 0, "a2");
        chk("a2_const", 64'(res_a), 64'h16A);
        op(0, 32'd0, 1'b0, 0, "a0");
        chk("a0_const", 64'(res_a), 64'h0);
        op(0, 32'hFFFF_FFFF, 1'b0, 0, "amax");
        chk("amax_const", 64'(res_a), 64'hFFFFFF);
        op(0, 32'd16, 1'b1, 0, "afault");
        chk("afault_const", 64'(res_a), 64'h401);
        op(1, 32'd16, 1'b0, 0, "b16");
        chk("b16_const", 64'(res_b), 64'h400);
        op(2, 32'hFFFF, 1'b0, 0, "cmax");
        chk("cmax_const", 64'(res_c), 64'h1FF);
        op(3, 32'hFFFF, 1'b0, 0, "dmax");
        op(1, 32'hFFFF_FFFF, 1'b0, 0, "bmax");

        // Start during ITER must be ignored
        op(0, 32'd12345, 1'b0, 5, "a_poke");
        op(1, 32'd777, 1'b0, 3, "b_poke");

        // Randomised operations against the model
        for (int i = 0; i < 30; i++) op(0, $urandom, ($urandom_range(0, 7) == 0), 0, "a_rnd");
        for (int i = 0; i < 30; i++) op(1, $urandom, ($urandom_range(0, 7) == 0), 0, "b_rnd");
        for (int i = 0; i < 60; i++) op(2, $urandom, ($urandom_range(0, 7) == 0), 0, "c_rnd");
        for (int i = 0; i < 256; i++) op(3, 32'(i), 1'b0, 0, "d_low");
        for (int i = 0; i < 150; i++) op(3, $urandom, 1'b0, 0, "d_rnd");

        // Back-to-back with Start held high: period NITER+2
        @(negedge clk);
        start[1] = 1'b1; inp[1] = 32'd1000;
        @(posedge clk);
        n = 0;
        #1;
        while (!done[1] && n < 200) begin @(posedge clk); n++; #1; end
        chk("b2b_first_lat", 64'(n), 64'(NIT[1] + 1));
        n2 = 0;
        while (done[1] && n2 < 200) begin @(posedge clk); n2++; #1; end
        while (!done[1] && n2 < 200) begin @(posedge clk); n2++; #1; end
        chk("b2b_period", 64'(n2), 64'(NIT[1] + 2));
        chk("b2b_res", 64'(res_b), 64'(ref_sqrt(1, 1000)));
        start[1] = 1'b0;
        @(posedge clk);

        // Reset mid-ITER aborts without a Done pulse
        @(negedge clk);
        start[0] = 1'b1; inp[0] = 32'd99999;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy[0]), 64'd0);
        chk("rst_mid_done", 64'(done[0]), 64'd0);
        chk("rst_mid_res", 64'(res_a), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin @(posedge clk); #1 if (done[0]) seen_done = 1'b1; end
        chk("rst_no_done", 64'(seen_done), 64'd0);
        op(0, 32'd16, 1'b0, 0, "a_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
